// File: rtl/spi_ram_burst.sv
// Command-decoding RAM behind an SPI slave (SET_WR/WRITE/SET_RD/READ) with optional pointer auto-increment.
// Read data is registered (1 cycle) and held in HOLD until tx_ready; a READ arriving while held and not consumed is dropped with err.
module spi_ram_burst #(
    parameter int MEM_DEPTH = 256,
    parameter int ADDR_SIZE = 8,
    parameter int MEM_WIDTH = 8,
    parameter bit AUTO_INC  = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [MEM_WIDTH+1:0] din,
    input  logic                 rx_valid,
    input  logic                 tx_ready,
    output logic [MEM_WIDTH-1:0] dout,
    output logic                 tx_valid,
    output logic                 err
);
    typedef enum logic [1:0] {
        CMD_SET_WR = 2'b00,
        CMD_WRITE  = 2'b01,
        CMD_SET_RD = 2'b10,
        CMD_READ   = 2'b11
    } cmd_e;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_HOLD = 1'b1
    } state_e;

    localparam logic [ADDR_SIZE-1:0] LAST_ADDR = ADDR_SIZE'(MEM_DEPTH - 1);

    logic [MEM_WIDTH-1:0] r_mem [MEM_DEPTH];
    logic [ADDR_SIZE-1:0] r_addr_wr;
    logic [ADDR_SIZE-1:0] r_addr_rd;
    logic [MEM_WIDTH-1:0] r_dout;
    logic                 r_tx_valid;
    logic                 r_err;
    state_e               r_state;

    cmd_e                 w_cmd;
    logic [MEM_WIDTH-1:0] w_payload;
    logic [ADDR_SIZE-1:0] w_addr;
    logic                 w_addr_ok;
    logic                 w_set_wr;
    logic                 w_write;
    logic                 w_set_rd;
    logic                 w_read;
    logic [ADDR_SIZE-1:0] w_addr_wr_nxt;
    logic [ADDR_SIZE-1:0] w_addr_rd_nxt;

    assign w_cmd     = cmd_e'(din[MEM_WIDTH+1:MEM_WIDTH]);
    assign w_payload = din[MEM_WIDTH-1:0];
    assign w_addr    = din[ADDR_SIZE-1:0];

    assign w_set_wr = rx_valid && (w_cmd == CMD_SET_WR);
    assign w_write  = rx_valid && (w_cmd == CMD_WRITE);
    assign w_set_rd = rx_valid && (w_cmd == CMD_SET_RD);
    assign w_read   = rx_valid && (w_cmd == CMD_READ);

    // A full power-of-two depth makes every pointer value legal.
    if (MEM_DEPTH == (1 << ADDR_SIZE)) begin : g_full_depth
        assign w_addr_ok = 1'b1;
    end else begin : g_part_depth
        assign w_addr_ok = (w_addr < ADDR_SIZE'(MEM_DEPTH));
    end

    assign w_addr_wr_nxt = (r_addr_wr == LAST_ADDR) ? '0 : r_addr_wr + ADDR_SIZE'(1);
    assign w_addr_rd_nxt = (r_addr_rd == LAST_ADDR) ? '0 : r_addr_rd + ADDR_SIZE'(1);

    always_ff @(posedge clk) begin
        if (!rst && w_write) begin
            r_mem[r_addr_wr] <= w_payload;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_tx_valid <= 1'b0;
            r_dout     <= '0;
            r_err      <= 1'b0;
            r_addr_wr  <= '0;
            r_addr_rd  <= '0;
        end else begin
            r_err <= 1'b0;
            if (w_set_wr) begin
                if (w_addr_ok) r_addr_wr <= w_addr;
                else           r_err     <= 1'b1;
            end
            if (w_write && AUTO_INC) begin
                r_addr_wr <= w_addr_wr_nxt;
            end
            if (w_set_rd) begin
                if (w_addr_ok) r_addr_rd <= w_addr;
                else           r_err     <= 1'b1;
            end
            case (r_state)
                S_IDLE: begin
                    if (w_read) begin
                        r_dout     <= r_mem[r_addr_rd];
                        r_state    <= S_HOLD;
                        r_tx_valid <= 1'b1;
                        if (AUTO_INC) r_addr_rd <= w_addr_rd_nxt;
                    end
                end
                S_HOLD: begin
                    if (tx_ready) begin
                        if (w_read) begin
                            r_dout <= r_mem[r_addr_rd];
                            if (AUTO_INC) r_addr_rd <= w_addr_rd_nxt;
                        end else begin
                            r_state    <= S_IDLE;
                            r_tx_valid <= 1'b0;
                        end
                    end else if (w_read) begin
                        // Unconsumed word still held: drop the new READ.
                        r_err <= 1'b1;
                    end
                end
                default: begin
                    r_state    <= S_IDLE;
                    r_tx_valid <= 1'b0;
                end
            endcase
        end
    end

    assign dout     = r_dout;
    assign tx_valid = r_tx_valid;
    assign err      = r_err;
endmodule

// File: tb/tb_spi_ram_burst.sv
// Bench for spi_ram_burst: three instances (256/auto-inc, 200/auto-inc, 256/static) share one stimulus stream.
module tb_spi_ram_burst;
    localparam logic [1:0] C_SWR = 2'b00, C_WR = 2'b01, C_SRD = 2'b10, C_RD = 2'b11;

    logic       clk = 1'b0;
    logic       rst;
    logic [9:0] din;
    logic       rx_valid;
    logic       tx_ready;
    logic [7:0] dout_a, dout_b, dout_c;
    logic       txv_a, txv_b, txv_c;
    logic       err_a, err_b, err_c;

    int n_cmp  = 0;
    int n_fail = 0;
    logic [7:0] exp_q [$];
    logic [7:0] exp_d;

    always #5 clk = ~clk;

    spi_ram_burst #(.MEM_DEPTH(256), .ADDR_SIZE(8), .MEM_WIDTH(8), .AUTO_INC(1'b1)) dut_a (
        .clk(clk), .rst(rst), .din(din), .rx_valid(rx_valid), .tx_ready(tx_ready),
        .dout(dout_a), .tx_valid(txv_a), .err(err_a));
    spi_ram_burst #(.MEM_DEPTH(200), .ADDR_SIZE(8), .MEM_WIDTH(8), .AUTO_INC(1'b1)) dut_b (
        .clk(clk), .rst(rst), .din(din), .rx_valid(rx_valid), .tx_ready(tx_ready),
        .dout(dout_b), .tx_valid(txv_b), .err(err_b));
    spi_ram_burst #(.MEM_DEPTH(256), .ADDR_SIZE(8), .MEM_WIDTH(8), .AUTO_INC(1'b0)) dut_c (
        .clk(clk), .rst(rst), .din(din), .rx_valid(rx_valid), .tx_ready(tx_ready),
        .dout(dout_c), .tx_valid(txv_c), .err(err_c));

    // Apply one command for one edge; outputs are sampled 1ns after that edge.
    task automatic drive(input logic rv, input logic [1:0] cmd, input logic [7:0] pl, input logic tr);
        rx_valid = rv;
        din      = {cmd, pl};
        tx_ready = tr;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(1'b0, C_SWR, 8'h00, 1'b0);
        drive(1'b0, C_SWR, 8'h00, 1'b0);
        n_cmp++; if (dout_a !== 8'h00) begin n_fail++; $display("FAIL reset_dout: got %h want 00", dout_a); end
        n_cmp++; if (txv_a !== 1'b0) begin n_fail++; $display("FAIL reset_txv: got %b want 0", txv_a); end
        n_cmp++; if (err_a !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b want 0", err_a); end
        rst = 1'b0;
        drive(1'b1, C_SWR, 8'h00, 1'b1);
        drive(1'b1, C_WR,  8'h5A, 1'b1);
        drive(1'b1, C_SWR, 8'h00, 1'b1);
        drive(1'b1, C_SRD, 8'h00, 1'b1);
        exp_q.push_back(8'h5A);
        drive(1'b1, C_RD, 8'h00, 1'b0);
        exp_d = exp_q.pop_front();
        n_cmp++; if (dout_a !== exp_d) begin n_fail++; $display("FAIL reset_pre_rd: got %h want %h", dout_a, exp_d); end
        n_cmp++; if (txv_a !== 1'b1) begin n_fail++; $display("FAIL reset_pre_txv: got %b want 1", txv_a); end
        // Reset while holding a word, with a WRITE on the same edge.
        rst = 1'b1;
        drive(1'b1, C_WR, 8'hC3, 1'b0);
        rst = 1'b0;
        n_cmp++; if (dout_a !== 8'h00) begin n_fail++; $display("FAIL reset_hold_dout: got %h want 00", dout_a); end
        n_cmp++; if (txv_a !== 1'b0) begin n_fail++; $display("FAIL reset_hold_txv: got %b want 0", txv_a); end
        n_cmp++; if (err_a !== 1'b0) begin n_fail++; $display("FAIL reset_hold_err: got %b want 0", err_a); end
        exp_q.push_back(8'h5A);
        drive(1'b1, C_RD, 8'h00, 1'b1);
        exp_d = exp_q.pop_front();
        n_cmp++; if (dout_a !== exp_d) begin n_fail++; $display("FAIL reset_no_write: got %h want %h", dout_a, exp_d); end
        drive(1'b0, C_SWR, 8'h00, 1'b1);
    endtask

    task automatic test_burst();
        logic [7:0] words [3] = '{8'h11, 8'h22, 8'h33};
        drive(1'b1, C_SWR, 8'hFE, 1'b1);
        for (int i = 0; i < 3; i++) drive(1'b1, C_WR, words[i], 1'b1);
        drive(1'b1, C_SRD, 8'hFE, 1'b1);
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back(words[i]);
            drive(1'b1, C_RD, 8'h00, 1'b1);
            exp_d = exp_q.pop_front();
            n_cmp++; if (dout_a !== exp_d) begin n_fail++; $display("FAIL burst_d%0d: got %h want %h", i, dout_a, exp_d); end
            n_cmp++; if (txv_a !== 1'b1) begin n_fail++; $display("FAIL burst_txv%0d: got %b want 1", i, txv_a); end
            n_cmp++; if (err_a !== 1'b0) begin n_fail++; $display("FAIL burst_err%0d: got %b want 0", i, err_a); end
        end
        drive(1'b0, C_SWR, 8'h00, 1'b1);
        n_cmp++; if (txv_a !== 1'b0) begin n_fail++; $display("FAIL burst_idle_txv: got %b want 0", txv_a); end
        n_cmp++; if (dout_a !== 8'h33) begin n_fail++; $display("FAIL burst_idle_dout: got %h want 33", dout_a); end
        // 0x33 was written after 0xFF wrapped to 0x00.
        drive(1'b1, C_SRD, 8'h00, 1'b1);
        exp_q.push_back(8'h33);
        drive(1'b1, C_RD, 8'h00, 1'b1);
        exp_d = exp_q.pop_front();
        n_cmp++; if (dout_a !== exp_d) begin n_fail++; $display("FAIL burst_wrap: got %h want %h", dout_a, exp_d); end
        drive(1'b0, C_SWR, 8'h00, 1'b1);
    endtask

    task automatic test_hold_overrun();
        drive(1'b1, C_SWR, 8'h10, 1'b1);
        drive(1'b1, C_WR,  8'hA1, 1'b1);
        drive(1'b1, C_WR,  8'hB2, 1'b1);
        drive(1'b1, C_SRD, 8'h10, 1'b1);
        exp_q.push_back(8'hA1);
        drive(1'b1, C_RD, 8'h00, 1'b0);
        exp_d = exp_q.pop_front();
        n_cmp++; if (dout_a !== exp_d) begin n_fail++; $display("FAIL hold_c0_dout: got %h want %h", dout_a, exp_d); end
        n_cmp++; if (err_a !== 1'b0) begin n_fail++; $display("FAIL hold_c0_err: got %b want 0", err_a); end
        drive(1'b1, C_RD, 8'h00, 1'b0);
        n_cmp++; if (dout_a !== exp_d) begin n_fail++; $display("FAIL hold_c1_dout: got %h want %h", dout_a, exp_d); end
        n_cmp++; if (txv_a !== 1'b1) begin n_fail++; $display("FAIL hold_c1_txv: got %b want 1", txv_a); end
        n_cmp++; if (err_a !== 1'b1) begin n_fail++; $display("FAIL hold_overrun_err: got %b want 1", err_a); end
        drive(1'b0, C_SWR, 8'h00, 1'b0);
        n_cmp++; if (dout_a !== exp_d) begin n_fail++; $display("FAIL hold_c2_dout: got %h want %h", dout_a, exp_d); end
        n_cmp++; if (txv_a !== 1'b1) begin n_fail++; $display("FAIL hold_c2_txv: got %b want 1", txv_a); end
        n_cmp++; if (err_a !== 1'b0) begin n_fail++; $display("FAIL hold_err_once: got %b want 0", err_a); end
        drive(1'b0, C_SWR, 8'h00, 1'b1);
        n_cmp++; if (txv_a !== 1'b0) begin n_fail++; $display("FAIL hold_release_txv: got %b want 0", txv_a); end
        n_cmp++; if (dout_a !== exp_d) begin n_fail++; $display("FAIL hold_release_dout: got %h want %h", dout_a, exp_d); end
        // The dropped READ must not have advanced the read pointer.
        exp_q.push_back(8'hB2);
        drive(1'b1, C_RD, 8'h00, 1'b1);
        exp_d = exp_q.pop_front();
        n_cmp++; if (dout_a !== exp_d) begin n_fail++; $display("FAIL hold_no_advance: got %h want %h", dout_a, exp_d); end
        drive(1'b0, C_SWR, 8'h00, 1'b1);
    endtask

    task automatic test_back_to_back();
        drive(1'b1, C_SRD, 8'h10, 1'b1);
        exp_q.push_back(8'hA1);
        drive(1'b1, C_RD, 8'h00, 1'b0);
        exp_d = exp_q.pop_front();
        n_cmp++; if (dout_a !== exp_d) begin n_fail++; $display("FAIL b2b_first: got %h want %h", dout_a, exp_d); end
        exp_q.push_back(8'hB2);
        drive(1'b1, C_RD, 8'h00, 1'b1);
        exp_d = exp_q.pop_front();
        n_cmp++; if (dout_a !== exp_d) begin n_fail++; $display("FAIL b2b_second: got %h want %h", dout_a, exp_d); end
        n_cmp++; if (txv_a !== 1'b1) begin n_fail++; $display("FAIL b2b_txv: got %b want 1", txv_a); end
        n_cmp++; if (err_a !== 1'b0) begin n_fail++; $display("FAIL b2b_err: got %b want 0", err_a); end
        drive(1'b0, C_SWR, 8'h00, 1'b1);
    endtask

    task automatic test_illegal();
        drive(1'b1, C_SWR, 8'h05, 1'b1);
        drive(1'b1, C_WR,  8'h77, 1'b1);
        drive(1'b1, C_SRD, 8'h05, 1'b1);
        n_cmp++; if (err_b !== 1'b0) begin n_fail++; $display("FAIL ill_legal_err: got %b want 0", err_b); end
        drive(1'b1, C_SRD, 8'hC8, 1'b1);
        n_cmp++; if (err_b !== 1'b1) begin n_fail++; $display("FAIL ill_rd_err: got %b want 1", err_b); end
        n_cmp++; if (err_a !== 1'b0) begin n_fail++; $display("FAIL ill_full_depth_err: got %b want 0", err_a); end
        drive(1'b0, C_SWR, 8'h00, 1'b1);
        n_cmp++; if (err_b !== 1'b0) begin n_fail++; $display("FAIL ill_rd_err_pulse: got %b want 0", err_b); end
        exp_q.push_back(8'h77);
        drive(1'b1, C_RD, 8'h00, 1'b1);
        exp_d = exp_q.pop_front();
        n_cmp++; if (dout_b !== exp_d) begin n_fail++; $display("FAIL ill_rd_unchanged: got %h want %h", dout_b, exp_d); end
        drive(1'b1, C_SWR, 8'hFF, 1'b1);
        n_cmp++; if (err_b !== 1'b1) begin n_fail++; $display("FAIL ill_wr_err: got %b want 1", err_b); end
        drive(1'b1, C_SWR, 8'hC7, 1'b1);
        drive(1'b1, C_WR,  8'h9E, 1'b1);
        drive(1'b1, C_WR,  8'h9F, 1'b1);
        drive(1'b1, C_SRD, 8'h00, 1'b1);
        exp_q.push_back(8'h9F);
        drive(1'b1, C_RD, 8'h00, 1'b1);
        exp_d = exp_q.pop_front();
        n_cmp++; if (dout_b !== exp_d) begin n_fail++; $display("FAIL ill_wr_wrap: got %h want %h", dout_b, exp_d); end
        drive(1'b1, C_SRD, 8'hC7, 1'b1);
        exp_q.push_back(8'h9E);
        drive(1'b1, C_RD, 8'h00, 1'b1);
        exp_d = exp_q.pop_front();
        n_cmp++; if (dout_b !== exp_d) begin n_fail++; $display("FAIL ill_last_addr: got %h want %h", dout_b, exp_d); end
        // 199 is the last address, so the next read wraps to 0.
        exp_q.push_back(8'h9F);
        drive(1'b1, C_RD, 8'h00, 1'b1);
        exp_d = exp_q.pop_front();
        n_cmp++; if (dout_b !== exp_d) begin n_fail++; $display("FAIL ill_rd_wrap: got %h want %h", dout_b, exp_d); end
        drive(1'b0, C_SWR, 8'h00, 1'b1);
    endtask

    task automatic test_no_autoinc();
        drive(1'b1, C_SWR, 8'h20, 1'b1);
        drive(1'b1, C_WR,  8'hAA, 1'b1);
        drive(1'b1, C_WR,  8'h55, 1'b1);
        drive(1'b1, C_SRD, 8'h20, 1'b1);
        for (int i = 0; i < 2; i++) begin
            exp_q.push_back(8'h55);
            drive(1'b1, C_RD, 8'h00, 1'b1);
            exp_d = exp_q.pop_front();
            n_cmp++; if (dout_c !== exp_d) begin n_fail++; $display("FAIL noinc_rd%0d: got %h want %h", i, dout_c, exp_d); end
        end
        drive(1'b0, C_SWR, 8'h00, 1'b1);
    endtask

    task automatic test_rx_invalid();
        drive(1'b1, C_SWR, 8'h30, 1'b1);
        drive(1'b1, C_WR,  8'h61, 1'b1);
        drive(1'b1, C_WR,  8'h62, 1'b1);
        drive(1'b1, C_SRD, 8'h30, 1'b1);
        drive(1'b0, C_RD,  8'h00, 1'b1);
        n_cmp++; if (txv_a !== 1'b0) begin n_fail++; $display("FAIL rxinv_txv: got %b want 0", txv_a); end
        n_cmp++; if (err_a !== 1'b0) begin n_fail++; $display("FAIL rxinv_err: got %b want 0", err_a); end
        exp_q.push_back(8'h61);
        drive(1'b1, C_RD, 8'h00, 1'b1);
        exp_d = exp_q.pop_front();
        n_cmp++; if (dout_a !== exp_d) begin n_fail++; $display("FAIL rxinv_ptr: got %h want %h", dout_a, exp_d); end
        drive(1'b0, C_SWR, 8'h00, 1'b1);
    endtask

    initial begin
        rst      = 1'b1;
        din      = '0;
        rx_valid = 1'b0;
        tx_ready = 1'b0;
        test_reset();
        test_burst();
        test_hold_overrun();
        test_back_to_back();
        test_illegal();
        test_no_autoinc();
        test_rx_invalid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
